// File: rtl/deser_pkg.sv
// Shared state type and counter-width helper for the deserializer frame controller.
// Latency: none (types and constant functions only).
// Backpressure: none.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        ACTIVE,
        DRAIN
    } deser_state_e;

    localparam int FRM_CNT_W = 16;

    // Bits needed to count n distinct values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deser_frame_ctrl_if.sv
// Serial-in / deserializer-control / word-out bundle for deser_frame_ctrl.
// Latency: none (wires only).
// Backpressure: frm_rdy is advisory; a word not accepted is lost, never stalled.
//   master: the frame controller (drives des_en/des_dir/frm_vld/frm_sof/frm_eof)
//   slave : the surrounding receive path (drives ser_vld/ser_in/des_valid/frm_rdy)
interface deser_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  ser_vld;
    logic [DATA_WIDTH-1:0] ser_in;
    logic                  des_en;
    logic                  des_dir;
    logic                  des_valid;
    logic                  frm_vld;
    logic                  frm_rdy;
    logic                  frm_sof;
    logic                  frm_eof;

    modport master (
        input  ser_vld, ser_in, des_valid, frm_rdy,
        output des_en, des_dir, frm_vld, frm_sof, frm_eof
    );

    modport slave (
        output ser_vld, ser_in, des_valid, frm_rdy,
        input  des_en, des_dir, frm_vld, frm_sof, frm_eof
    );
endinterface

// File: rtl/deser_frame_ctrl.sv
// Frame sequencer: hunts SYNC_WORD, enables the Deserializer for FRAME_LEN words, tags sof/eof.
// Latency: des_en combinational; frm_vld/sof/eof/err_ovf follow des_valid in the same cycle.
// Backpressure: none; frm_rdy low on a valid word pulses err_ovf and the word is dropped.
// Ports: clk, rst (async active-high), start/loop/abort/dir_cfg controls, bus (master modport),
//        busy, frm_cnt (completed frames, wraps), err_gap/err_ovf/err_tmo pulses.
// Optional: DESER_CTRL_TIMEOUT_EN adds a HUNT timeout of TIMEOUT_CYC cycles.
module deser_frame_ctrl
    import deser_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    PARL_WIDTH  = 8,
    parameter int                    FRAME_LEN   = 4,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = 8'hA5,
    parameter int                    TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 loop,
    input  logic                 abort,
    input  logic                 dir_cfg,
    deser_frame_ctrl_if.master   bus,
    output logic                 busy,
    output logic [FRM_CNT_W-1:0] frm_cnt,
    output logic                 err_gap,
    output logic                 err_ovf,
    output logic                 err_tmo
);

    localparam int               SYM_W     = cnt_w(PARL_WIDTH);
    localparam int               WORD_W    = cnt_w(FRAME_LEN);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(PARL_WIDTH - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_LEN - 1);

    deser_state_e         state_q, state_d;
    logic [SYM_W-1:0]     sym_q, sym_d;     // symbol position inside the word being fed
    logic [WORD_W-1:0]    fed_q, fed_d;     // words fully fed into the Deserializer
    logic [WORD_W-1:0]    out_q, out_d;     // words presented downstream (lags fed by one word)
    logic                 dir_q, dir_d;
    logic [FRM_CNT_W-1:0] cnt_q, cnt_d;
    logic                 gap_q, gap_d;
    logic                 tmo_q, tmo_d;
    logic                 timeout_hit;
    logic                 word_vld;

`ifdef DESER_CTRL_TIMEOUT_EN
    localparam int               TMO_W    = cnt_w(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    assign timeout_hit = (state_q == HUNT) && (tmo_cnt_q == TMO_LAST);

    // Counts consecutive HUNT cycles; any exit from HUNT restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == HUNT) && (state_d == HUNT)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // The Deserializer only has a word to show after being fed, so gating by
    // state just hides anything left over once the frame is abandoned.
    assign word_vld    = bus.des_valid && ((state_q == ACTIVE) || (state_q == DRAIN));
    assign bus.des_en  = (state_q == ACTIVE) && bus.ser_vld;
    assign bus.des_dir = dir_q;
    assign bus.frm_vld = word_vld;
    assign bus.frm_sof = word_vld && (out_q == '0);
    assign bus.frm_eof = word_vld && (out_q == WORD_LAST);
    assign err_ovf     = word_vld && !bus.frm_rdy;
    assign busy        = (state_q != IDLE);
    assign frm_cnt     = cnt_q;
    assign err_gap     = gap_q;
    assign err_tmo     = tmo_q;

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        fed_d   = fed_q;
        out_d   = out_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        gap_d   = 1'b0;
        tmo_d   = 1'b0;

        if (word_vld) begin
            out_d = out_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir_cfg;
                    state_d = HUNT;
                end
            end
            HUNT: begin
                // A sync arriving on the timeout cycle still wins.
                if (bus.ser_vld && (bus.ser_in == SYNC_WORD)) begin
                    state_d = ACTIVE;
                end else if (timeout_hit) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (bus.ser_vld) begin
                    if (sym_q == SYM_LAST) begin
                        sym_d = '0;
                        if (fed_q == WORD_LAST) begin
                            fed_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            fed_d = fed_q + 1'b1;
                        end
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end else if (sym_q != '0) begin
                    // Missing symbol inside a word: the partial word is unusable.
                    gap_d   = 1'b1;
                    sym_d   = '0;
                    fed_d   = '0;
                    out_d   = '0;
                    state_d = HUNT;
                end
            end
            DRAIN: begin
                cnt_d   = cnt_q + 1'b1;
                sym_d   = '0;
                fed_d   = '0;
                out_d   = '0;
                state_d = loop ? HUNT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            sym_d   = '0;
            fed_d   = '0;
            out_d   = '0;
            cnt_d   = cnt_q;
            gap_d   = 1'b0;
            tmo_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sym_q   <= '0;
            fed_q   <= '0;
            out_q   <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            fed_q   <= fed_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Bench for deser_frame_ctrl: directed per-cycle stimulus tables, a stream-level expectation
// model, a per-cycle compare process, and hand-computed literal checks per scenario.
// Expectations for err_tmo follow DESER_CTRL_TIMEOUT_EN when it is defined.
module tb_deser_frame_ctrl;

    localparam int          DW   = 8;
    localparam int          PW   = 8;
    localparam int          FL   = 4;
    localparam int          TMO  = 16;
    localparam int          MAXC = 96;
    localparam logic [7:0]  SYNC = 8'hA5;
`ifdef DESER_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_HUNT = 1, M_COLL = 2, M_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, loop = 1'b0, abort = 1'b0, dir_cfg = 1'b0;
    logic        busy, err_gap, err_ovf, err_tmo;
    logic [15:0] frm_cnt;

    deser_frame_ctrl_if #(.DATA_WIDTH(DW)) bus();

    deser_frame_ctrl #(
        .DATA_WIDTH (DW),
        .PARL_WIDTH (PW),
        .FRAME_LEN  (FL),
        .SYNC_WORD  (SYNC),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .loop   (loop),
        .abort  (abort),
        .dir_cfg(dir_cfg),
        .bus    (bus),
        .busy   (busy),
        .frm_cnt(frm_cnt),
        .err_gap(err_gap),
        .err_ovf(err_ovf),
        .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    // Stand-in for the neighbouring Deserializer: PW enabled symbols -> one valid cycle.
    int dcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt          <= 0;
            bus.des_valid <= 1'b0;
        end else begin
            bus.des_valid <= bus.des_en && (dcnt == PW - 1);
            if (!bus.des_en || dcnt == PW - 1) dcnt <= 0;
            else                               dcnt <= dcnt + 1;
        end
    end

    // Stimulus tables and expectations, one entry per cycle of a scenario.
    bit         s_start[MAXC], s_loop[MAXC], s_abort[MAXC], s_dir[MAXC], s_vld[MAXC], s_rdy[MAXC];
    logic [7:0] s_in[MAXC];
    logic [8:0] exp_o[MAXC];   // {busy,des_en,des_dir,frm_vld,frm_sof,frm_eof,err_gap,err_ovf,err_tmo}
    logic [15:0] exp_cnt[MAXC];

    int    n_chk = 0, n_fail = 0;
    int    cyc = 0;
    bit    chk_on = 1'b0;
    string tname = "reset";

    // Per-scenario observations for literal checks.
    int    r_vld_cyc[$];
    int    r_en_n, r_busy_n, r_sof_n, r_sof_cyc, r_eof_n, r_eof_cyc;
    int    r_gap_n, r_gap_cyc, r_ovf_n, r_ovf_cyc, r_tmo_n, r_tmo_cyc, r_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int vld_at(input int k);
        return (k < r_vld_cyc.size()) ? r_vld_cyc[k] : -1;
    endfunction

    // Stream-level model: walks the stimulus table and says what each cycle must show.
    task automatic build_expect(input int len);
        int mode  = M_IDLE;
        int nsym  = 0;      // symbols taken into the current frame
        int words = 0;      // words already shown downstream in this frame
        int hunt  = 0;      // HUNT cycles spent since the hunt began
        int cnt   = 0;
        bit pend  = 0, gap = 0, tmo = 0, dir = 0;
        bit en, fv;
        for (int i = 0; i < len; i++) begin
            en = (mode == M_COLL) && s_vld[i];
            fv = pend && (mode == M_COLL || mode == M_DRAIN);
            exp_o[i]   = {mode != M_IDLE, en, dir, fv, fv && words == 0, fv && words == FL - 1,
                          gap, fv && !s_rdy[i], tmo};
            exp_cnt[i] = 16'(cnt);
            pend = en && (nsym % PW == PW - 1);
            if (fv) words++;
            gap = 0;
            tmo = 0;
            if (s_abort[i]) begin
                mode = M_IDLE; nsym = 0; words = 0;
            end else begin
                case (mode)
                    M_IDLE: if (s_start[i]) begin dir = s_dir[i]; mode = M_HUNT; hunt = 0; end
                    M_HUNT: begin
                        hunt++;
                        if (s_vld[i] && s_in[i] == SYNC) mode = M_COLL;
                        else if (TMO_EN && hunt == TMO) begin tmo = 1; mode = M_IDLE; end
                    end
                    M_COLL: begin
                        if (s_vld[i]) begin
                            nsym++;
                            if (nsym == FL * PW) mode = M_DRAIN;
                        end else if (nsym % PW != 0) begin
                            gap = 1; mode = M_HUNT; nsym = 0; words = 0; hunt = 0;
                        end
                    end
                    default: begin
                        cnt++; nsym = 0; words = 0; hunt = 0;
                        mode = s_loop[i] ? M_HUNT : M_IDLE;
                    end
                endcase
            end
        end
    endtask

    // Single compare process: every scenario cycle, against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk($sformatf("%s outs cyc%0d", tname, cyc),
                {busy, bus.des_en, bus.des_dir, bus.frm_vld, bus.frm_sof, bus.frm_eof,
                 err_gap, err_ovf, err_tmo}, exp_o[cyc]);
            chk($sformatf("%s frm_cnt cyc%0d", tname, cyc), frm_cnt, exp_cnt[cyc]);
            if (bus.frm_vld) r_vld_cyc.push_back(cyc);
            if (bus.des_en)  r_en_n++;
            if (busy)        r_busy_n++;
            if (bus.frm_sof) begin r_sof_n++; r_sof_cyc = cyc; end
            if (bus.frm_eof) begin r_eof_n++; r_eof_cyc = cyc; end
            if (err_gap)     begin r_gap_n++; r_gap_cyc = cyc; end
            if (err_ovf)     begin r_ovf_n++; r_ovf_cyc = cyc; end
            if (err_tmo)     begin r_tmo_n++; r_tmo_cyc = cyc; end
            r_cnt = frm_cnt;
        end
    end

    task automatic clr_stim();
        for (int i = 0; i < MAXC; i++) begin
            s_start[i] = 0; s_loop[i] = 0; s_abort[i] = 0; s_dir[i] = 0;
            s_vld[i] = 0; s_in[i] = 8'h00; s_rdy[i] = 1;
        end
    endtask

    task automatic frame_at(input int c0);
        s_vld[c0] = 1;
        s_in[c0]  = SYNC;
        for (int k = 0; k < FL * PW; k++) begin
            s_vld[c0 + 1 + k] = 1;
            s_in[c0 + 1 + k]  = 8'(k * 37 + 1);
        end
    endtask

    task automatic junk(input int c0, input int n);
        for (int k = 0; k < n; k++) begin
            s_vld[c0 + k] = 1;
            s_in[c0 + k]  = 8'h3C;
        end
    endtask

    task automatic do_reset();
        chk_on = 0;
        rst = 1; start = 0; loop = 0; abort = 0; dir_cfg = 0;
        bus.ser_vld = 0; bus.ser_in = '0; bus.frm_rdy = 1;
        @(posedge clk);
        @(negedge clk);
        chk("reset outs", {busy, bus.des_en, bus.des_dir, bus.frm_vld, bus.frm_sof,
                           bus.frm_eof, err_gap, err_ovf, err_tmo}, 9'd0);
        chk("reset frm_cnt", frm_cnt, 16'd0);
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic run_test(input string name, input int len);
        tname = name;
        build_expect(len);
        r_vld_cyc.delete();
        r_en_n = 0; r_busy_n = 0; r_sof_n = 0; r_sof_cyc = -1; r_eof_n = 0; r_eof_cyc = -1;
        r_gap_n = 0; r_gap_cyc = -1; r_ovf_n = 0; r_ovf_cyc = -1; r_tmo_n = 0; r_tmo_cyc = -1;
        r_cnt = -1;
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            start = s_start[i]; loop = s_loop[i]; abort = s_abort[i]; dir_cfg = s_dir[i];
            bus.ser_vld = s_vld[i]; bus.ser_in = s_in[i]; bus.frm_rdy = s_rdy[i];
            cyc = i;
            chk_on = 1;
        end
        @(posedge clk);
        #1 chk_on = 0;
    endtask

    initial begin
        bus.ser_vld = 0; bus.ser_in = '0; bus.frm_rdy = 1;

        // T1: single frame, loop=0; a stray start during the frame is ignored.
        do_reset();
        clr_stim();
        s_start[0] = 1;
        frame_at(1);
        s_start[5] = 1; s_dir[5] = 1;
        run_test("t1_frame", 38);
        chk("t1 words", r_vld_cyc.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t1 word%0d cyc", k), vld_at(k), 10 + 8 * k);
        chk("t1 des_en cycles", r_en_n, 32);
        chk("t1 sof cyc", r_sof_cyc, 10);
        chk("t1 eof cyc", r_eof_cyc, 34);
        chk("t1 sof count", r_sof_n, 1);
        chk("t1 busy cycles", r_busy_n, 34);
        chk("t1 frm_cnt", r_cnt, 1);

        // T2: loop=1, two frames with five junk symbols between, dir=1.
        do_reset();
        clr_stim();
        s_start[0] = 1; s_dir[0] = 1;
        for (int i = 0; i < 73; i++) s_loop[i] = 1;
        frame_at(1);
        junk(35, 5);
        frame_at(40);
        run_test("t2_loop", 78);
        chk("t2 words", r_vld_cyc.size(), 8);
        chk("t2 busy cycles", r_busy_n, 73);
        chk("t2 eof count", r_eof_n, 2);
        chk("t2 frm_cnt", r_cnt, 2);

        // T3: ser_vld drops after the 3rd symbol of word 2.
        do_reset();
        clr_stim();
        s_start[0] = 1;
        frame_at(1);
        for (int i = 13; i < MAXC; i++) s_vld[i] = 0;
        junk(14, 7);
        run_test("t3_gap", 24);
        chk("t3 gap count", r_gap_n, 1);
        chk("t3 gap cyc", r_gap_cyc, 14);
        chk("t3 words", r_vld_cyc.size(), 1);
        chk("t3 busy cycles", r_busy_n, 23);
        chk("t3 frm_cnt", r_cnt, 0);

        // T4: downstream not ready for the 2nd word.
        do_reset();
        clr_stim();
        s_start[0] = 1;
        frame_at(1);
        s_rdy[5] = 0; s_rdy[18] = 0;
        run_test("t4_ovf", 38);
        chk("t4 ovf count", r_ovf_n, 1);
        chk("t4 ovf cyc", r_ovf_cyc, 18);
        chk("t4 words", r_vld_cyc.size(), 4);
        chk("t4 frm_cnt", r_cnt, 1);

        // T5: abort in the cycle the 2nd word is presented.
        do_reset();
        clr_stim();
        s_start[0] = 1;
        frame_at(1);
        s_abort[18] = 1;
        run_test("t5_abort", 30);
        chk("t5 words", r_vld_cyc.size(), 2);
        chk("t5 last word cyc", vld_at(1), 18);
        chk("t5 busy cycles", r_busy_n, 18);
        chk("t5 frm_cnt", r_cnt, 0);

        // T6: asynchronous reset mid-frame, with dir=1 latched.
        do_reset();
        clr_stim();
        s_start[0] = 1; s_dir[0] = 1;
        frame_at(1);
        run_test("t6_rst", 15);
        chk("t6 pre-reset busy/en/dir", {busy, bus.des_en, bus.des_dir}, 3'b111);
        #2 rst = 1;
        #1;
        chk("t6 async reset outs", {busy, bus.des_en, bus.des_dir, bus.frm_vld, bus.frm_sof,
                                    bus.frm_eof, err_gap, err_ovf, err_tmo}, 9'd0);
        chk("t6 async reset frm_cnt", frm_cnt, 16'd0);

        // T7: start with no sync ever arriving.
        do_reset();
        clr_stim();
        s_start[0] = 1;
        junk(1, 25);
        run_test("t7_hunt", 30);
        if (TMO_EN) begin
            chk("t7 tmo count", r_tmo_n, 1);
            chk("t7 tmo cyc", r_tmo_cyc, 17);
            chk("t7 busy cycles", r_busy_n, 16);
        end else begin
            chk("t7 tmo count", r_tmo_n, 0);
            chk("t7 busy cycles", r_busy_n, 29);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
